// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-neural-network dot-product feeder:
// feeder FSM states, default vector geometry and accumulator width.
package bnn_pkg;

  localparam int BNN_N_BITS = 64;
  localparam int BNN_WORD_W = 32;
  localparam int BNN_ACC_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_GAP       = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESULT    = 3'd5
  } state_e;

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Counts matching bit positions between an activation word and a weight
// word (population count of their XNOR).
module bnn_xnor_popcount #(
  parameter int WORD_W = 32,
  parameter int PC_W   = $clog2(WORD_W) + 1
) (
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] w_word,
  output logic [PC_W-1:0]   pop
);

  logic [WORD_W-1:0] xnor_s;

  // Sum the matching-bit flags of the two words.
  always_comb begin
    xnor_s = ~(a_word ^ w_word);
    pop    = {PC_W{1'b0}};
    for (int i = 0; i < WORD_W; i++) begin
      pop = pop + {{(PC_W-1){1'b0}}, xnor_s[i]};
    end
  end

endmodule

// File: rtl/bnn_dot_feeder.sv
// Feeds two binary vectors word by word into an external XNOR-popcount dot
// engine, waits (bounded) for its result and offers it on a valid/ready port.
// Optional build macro BNN_DOT_FEEDER_CHECK_EN adds an independent running
// expectation of the dot product and flags res_mismatch when the engine differs.
module bnn_dot_feeder
  import bnn_pkg::*;
#(
  parameter int N_BITS      = BNN_N_BITS,
  parameter int WORD_W      = BNN_WORD_W,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [N_BITS-1:0]           cmd_a_vec,
  input  logic [N_BITS-1:0]           cmd_w_vec,
  output logic                        eng_start,
  output logic [WORD_W-1:0]           eng_a_word,
  output logic [WORD_W-1:0]           eng_w_word,
  output logic                        eng_word_valid,
  output logic                        eng_last_word,
  input  logic                        eng_done,
  input  logic signed [BNN_ACC_W-1:0] eng_acc,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [BNN_ACC_W-1:0] res_acc,
  output logic                        res_err,
  output logic                        res_mismatch
);

  localparam int NUM_WORDS = N_BITS / WORD_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

  state_e                      state_q, state_d;
  logic [N_BITS-1:0]           a_vec_q, a_vec_d, w_vec_q, w_vec_d;
  logic [N_BITS-1:0]           a_sh_s, w_sh_s;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        tmo_hit_s, accept_s;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        eng_start_q, eng_start_d;
  logic [WORD_W-1:0]           eng_a_word_q, eng_a_word_d, eng_w_word_q, eng_w_word_d;
  logic                        eng_word_valid_q, eng_word_valid_d;
  logic                        eng_last_word_q, eng_last_word_d;
  logic                        res_valid_q, res_valid_d;
  logic signed [BNN_ACC_W-1:0] res_acc_q, res_acc_d;
  logic                        res_err_q, res_err_d;

  assign accept_s  = cmd_valid && cmd_ready_q;
  assign tmo_hit_s = ((tmo_q + TMO_W'(1)) == TMO_LIMIT);

  // Next-state and next-output logic; every output is computed one cycle ahead.
  always_comb begin
    state_d          = state_q;
    a_vec_d          = a_vec_q;
    w_vec_d          = w_vec_q;
    idx_d            = idx_q;
    tmo_d            = tmo_q;
    cmd_ready_d      = 1'b0;
    eng_start_d      = 1'b0;
    eng_word_valid_d = 1'b0;
    eng_last_word_d  = 1'b0;
    res_valid_d      = res_valid_q;
    res_acc_d        = res_acc_q;
    res_err_d        = res_err_q;
    case (state_q)
      ST_IDLE: begin
        res_valid_d = 1'b0;
        if (accept_s) begin
          a_vec_d     = cmd_a_vec;
          w_vec_d     = cmd_w_vec;
          eng_start_d = 1'b1;
          state_d     = ST_START;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        idx_d            = {IDX_W{1'b0}};
        eng_word_valid_d = 1'b1;
        eng_last_word_d  = (LAST_IDX == {IDX_W{1'b0}});
        state_d          = ST_STREAM;
      end
      ST_STREAM: begin
        if (idx_q == LAST_IDX) begin
          tmo_d   = {TMO_W{1'b0}};
          state_d = ST_WAIT_DONE;
        end else begin
          idx_d            = idx_q + IDX_W'(1);
          eng_word_valid_d = 1'b1;
          eng_last_word_d  = ((idx_q + IDX_W'(1)) == LAST_IDX);
        end
      end
      ST_WAIT_DONE: begin
        if (eng_done) begin
          res_acc_d   = eng_acc;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else if (tmo_hit_s) begin
          res_acc_d   = {BNN_ACC_W{1'b0}};
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_RESULT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RESULT: begin
        res_valid_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
    // Word selection for the index that will be on the outputs next cycle.
    a_sh_s = a_vec_q >> (WORD_W * int'(idx_d));
    w_sh_s = w_vec_q >> (WORD_W * int'(idx_d));
    if (eng_word_valid_d) begin
      eng_a_word_d = a_sh_s[WORD_W-1:0];
      eng_w_word_d = w_sh_s[WORD_W-1:0];
    end else begin
      eng_a_word_d = {WORD_W{1'b0}};
      eng_w_word_d = {WORD_W{1'b0}};
    end
  end

  // State, captured vectors, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      a_vec_q          <= {N_BITS{1'b0}};
      w_vec_q          <= {N_BITS{1'b0}};
      idx_q            <= {IDX_W{1'b0}};
      tmo_q            <= {TMO_W{1'b0}};
      cmd_ready_q      <= 1'b1;
      eng_start_q      <= 1'b0;
      eng_a_word_q     <= {WORD_W{1'b0}};
      eng_w_word_q     <= {WORD_W{1'b0}};
      eng_word_valid_q <= 1'b0;
      eng_last_word_q  <= 1'b0;
      res_valid_q      <= 1'b0;
      res_acc_q        <= {BNN_ACC_W{1'b0}};
      res_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      a_vec_q          <= a_vec_d;
      w_vec_q          <= w_vec_d;
      idx_q            <= idx_d;
      tmo_q            <= tmo_d;
      cmd_ready_q      <= cmd_ready_d;
      eng_start_q      <= eng_start_d;
      eng_a_word_q     <= eng_a_word_d;
      eng_w_word_q     <= eng_w_word_d;
      eng_word_valid_q <= eng_word_valid_d;
      eng_last_word_q  <= eng_last_word_d;
      res_valid_q      <= res_valid_d;
      res_acc_q        <= res_acc_d;
      res_err_q        <= res_err_d;
    end
  end

`ifdef BNN_DOT_FEEDER_CHECK_EN
  localparam int PC_W = $clog2(WORD_W) + 1;
  localparam logic [BNN_ACC_W-1:0] WORD_W_ACC = BNN_ACC_W'(WORD_W);

  logic [PC_W-1:0]             pop_s;
  logic [BNN_ACC_W-1:0]        term_s;
  logic signed [BNN_ACC_W-1:0] exp_q, exp_d;
  logic                        res_mismatch_q, res_mismatch_d;

  bnn_xnor_popcount #(.WORD_W(WORD_W), .PC_W(PC_W)) u_pop (
    .a_word (eng_a_word_q),
    .w_word (eng_w_word_q),
    .pop    (pop_s)
  );

  // Running expectation: each emitted word adds 2*matches - WORD_W.
  always_comb begin
    term_s         = {{(BNN_ACC_W-PC_W-1){1'b0}}, pop_s, 1'b0} - WORD_W_ACC;
    exp_d          = exp_q;
    res_mismatch_d = res_mismatch_q;
    if (accept_s) begin
      exp_d = {BNN_ACC_W{1'b0}};
    end else if (eng_word_valid_q) begin
      exp_d = exp_q + $signed(term_s);
    end else begin
      exp_d = exp_q;
    end
    if (state_q == ST_WAIT_DONE && eng_done) begin
      res_mismatch_d = (eng_acc != exp_q);
    end else if (state_q == ST_WAIT_DONE && tmo_hit_s) begin
      res_mismatch_d = 1'b0;
    end else begin
      res_mismatch_d = res_mismatch_q;
    end
  end

  // Expectation accumulator and registered mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q          <= {BNN_ACC_W{1'b0}};
      res_mismatch_q <= 1'b0;
    end else begin
      exp_q          <= exp_d;
      res_mismatch_q <= res_mismatch_d;
    end
  end

  assign res_mismatch = res_mismatch_q;
`else
  assign res_mismatch = 1'b0;
`endif

  assign cmd_ready      = cmd_ready_q;
  assign eng_start      = eng_start_q;
  assign eng_a_word     = eng_a_word_q;
  assign eng_w_word     = eng_w_word_q;
  assign eng_word_valid = eng_word_valid_q;
  assign eng_last_word  = eng_last_word_q;
  assign res_valid      = res_valid_q;
  assign res_acc        = res_acc_q;
  assign res_err        = res_err_q;

endmodule

// File: doc/bnn_dot_feeder.md
BNN_DOT_FEEDER -- requirements
Module: bnn_dot_feeder

Interface
REQ-001 The block SHALL have parameter N_BITS, default 64: binary vector length in bits.
REQ-002 The block SHALL have parameter WORD_W, default 32: bits per streamed word; N_BITS SHALL be a multiple of WORD_W, and NUM_WORDS = N_BITS/WORD_W.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 256: maximum number of cycles to wait for engine done.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the ports are clk and rst.
REQ-005 The block SHALL have the port clk, input, 1 bit: the clock.
REQ-006 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have the port cmd_valid, input, 1 bit: a command is offered.
REQ-008 The block SHALL have the port cmd_ready, output, 1 bit: the block can accept a command.
REQ-009 The block SHALL have the port cmd_a_vec, input, N_BITS: activation vector.
REQ-010 The block SHALL have the port cmd_w_vec, input, N_BITS: weight vector.
REQ-011 The block SHALL have the port eng_start, output, 1 bit: start pulse to the dot engine.
REQ-012 The block SHALL have the port eng_a_word, output, WORD_W: activation word.
REQ-013 The block SHALL have the port eng_w_word, output, WORD_W: weight word.
REQ-014 The block SHALL have the port eng_word_valid, output, 1 bit: the word pair is valid.
REQ-015 The block SHALL have the port eng_last_word, output, 1 bit: final word of the vector.
REQ-016 The block SHALL have the port eng_done, input, 1 bit: the engine result is ready.
REQ-017 The block SHALL have the port eng_acc, input, 32-bit signed: engine result.
REQ-018 The block SHALL have the port res_valid, output, 1 bit: a result is offered.
REQ-019 The block SHALL have the port res_ready, input, 1 bit: the consumer accepts the result.
REQ-020 The block SHALL have the port res_acc, output, 32-bit signed: captured result.
REQ-021 The block SHALL have the port res_err, output, 1 bit: the done timeout expired.
REQ-022 The block SHALL have the port res_mismatch, output, 1 bit: self-check failure (see Configuration).

Function
REQ-023 The FSM SHALL have the states IDLE, START, GAP, STREAM, WAIT_DONE, RESULT; all outputs SHALL be registered.
REQ-024 In IDLE, cmd_ready SHALL be 1 and SHALL be 0 in every other state; on cmd_valid&&cmd_ready (cycle T) the block SHALL capture both vectors and enter START.
REQ-025 In START (T+1), eng_start SHALL be 1 for exactly one cycle; in GAP (T+2), all engine outputs SHALL be 0.
REQ-026 In STREAM, for word index k=0..NUM_WORDS-1 at cycle T+3+k, eng_word_valid SHALL be 1, with eng_a_word=cmd_a_vec[k*WORD_W +: WORD_W] and eng_w_word likewise (LSB word first).
REQ-027 eng_last_word SHALL be 1 only when k=NUM_WORDS-1; the word counter SHALL not wrap, and after the last word the FSM SHALL enter WAIT_DONE.
REQ-028 In WAIT_DONE, eng_word_valid and eng_last_word SHALL be 0; when eng_done=1, the block SHALL capture eng_acc into res_acc, set res_err=0, and enter RESULT.
REQ-029 eng_done SHALL be ignored in all states other than WAIT_DONE.
REQ-030 If the WAIT_DONE cycle counter reaches TIMEOUT_CYC, the block SHALL set res_err=1 and res_acc=0, and enter RESULT.
REQ-031 In RESULT, res_valid SHALL be 1 and res_acc/res_err/res_mismatch SHALL be stable until res_valid&&res_ready, after which the block SHALL enter IDLE with res_valid=0.
REQ-032 The command-to-result minimum latency SHALL be NUM_WORDS+4 cycles, given an engine done one cycle after the last word.

Reset
REQ-033 When rst=1 at a clk edge, the block SHALL set the FSM to IDLE and zero the counters; eng_* outputs, res_valid, res_acc, res_err and res_mismatch SHALL be 0, and cmd_ready SHALL be 1 from the following cycle.
REQ-034 A reset asserted mid-STREAM or in WAIT_DONE SHALL abort the operation, and no further engine word SHALL be emitted for that command.

Configuration
REQ-035 When macro BNN_DOT_FEEDER_CHECK_EN is defined, the block SHALL accumulate exp += 2*popcount(~(a_word^w_word)) - WORD_W per streamed word, and at eng_done SHALL set res_mismatch = (eng_acc != exp).
REQ-036 When BNN_DOT_FEEDER_CHECK_EN is undefined, the block SHALL contain no check logic, and res_mismatch SHALL be tied to 0.
REQ-037 On timeout, res_mismatch SHALL be 0 in both builds.

Structure
REQ-038 The shared package bnn_pkg SHALL hold the FSM state enum, the default N_BITS/WORD_W constants, and the 32-bit accumulator width constant.
REQ-039 The word XNOR-popcount (WORD_W in, clog2(WORD_W)+1 out) SHALL be the sub-module bnn_xnor_popcount, instantiated only under BNN_DOT_FEEDER_CHECK_EN.

Verification
REQ-040 a=64'hFFFFFFFF_FFFFFFFF, w=64'h00000000_FFFFFFFF, engine model -> eng_start at T+1, words at T+3 (last=0) and T+4 (last=1); res_acc=0, res_mismatch=0.
REQ-041 a=w=all ones -> res_acc=+64; a=all ones, w=all zeros -> res_acc=-64.
REQ-042 res_ready held 0 for 5 cycles in RESULT -> res_valid and res_acc stay stable, cmd_ready=0, and a second cmd_valid is not accepted until the result handshake completes.
REQ-043 Engine model never asserts done -> res_valid with res_err=1 and res_acc=0 exactly TIMEOUT_CYC cycles after WAIT_DONE entry.
REQ-044 rst pulsed during word 1 -> next cycle all outputs 0 and cmd_ready=1, no eng_last_word seen; the next command completes correctly.
REQ-045 BNN_DOT_FEEDER_CHECK_EN defined, engine model returns expected+2 -> res_mismatch=1; correct engine -> res_mismatch=0.
